// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package mips_hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: stage operand/destination
// info in, per-register enables/clears, error pulse and counters out.
interface mips_hazard_ctrl_if #(parameter int CNT_W = 32);

    logic [mips_hazard_pkg::REG_W-1:0] i_RsD, i_RtD, i_RtE, i_WriteRegE;
    logic                              i_BranchD, i_PCSrcD, i_RegWriteE;
    logic [1:0]                        i_MemtoRegE;
    logic                              i_MemReqM, i_MemReadyM;

    logic             o_WE_nF, o_WE_nD, o_WE_nE, o_WE_nM, o_WE_nW;
    logic             o_CLR_D, o_CLR_E, o_CLR_W;
    logic             o_MemErr;
    logic [CNT_W-1:0] o_StallCnt, o_FlushCnt;

    modport master (
        output i_RsD, i_RtD, i_RtE, i_WriteRegE, i_BranchD, i_PCSrcD,
               i_RegWriteE, i_MemtoRegE, i_MemReqM, i_MemReadyM,
        input  o_WE_nF, o_WE_nD, o_WE_nE, o_WE_nM, o_WE_nW,
               o_CLR_D, o_CLR_E, o_CLR_W, o_MemErr, o_StallCnt, o_FlushCnt
    );

    modport slave (
        input  i_RsD, i_RtD, i_RtE, i_WriteRegE, i_BranchD, i_PCSrcD,
               i_RegWriteE, i_MemtoRegE, i_MemReqM, i_MemReadyM,
        output o_WE_nF, o_WE_nD, o_WE_nE, o_WE_nM, o_WE_nW,
               o_CLR_D, o_CLR_E, o_CLR_W, o_MemErr, o_StallCnt, o_FlushCnt
    );

endinterface

// File: rtl/mips_hazard_perf_cnt.sv
// Stall and flush event counters; both wrap modulo 2^CNT_W.
module mips_hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             i_Clk,
    input  logic             Reset,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    always_ff @(posedge i_Clk) begin
        if (Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Five-stage MIPS hazard controller: load-use / branch-operand bubbles and a
// memory-wait FSM with watchdog. Define HAZARD_PERF_CNT_EN for perf counters.
module mips_hazard_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 i_Clk,
    input  logic                 Reset,
    mips_hazard_ctrl_if.slave    hz
);

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    hz_state_e     state;
    logic [TW-1:0] cnt;
    logic          mem_err;
    logic          tmo, memstall, lu, bu;
    logic          we_f, we_d, we_e, we_m, we_w;
    logic          clr_d, clr_e, clr_w;

    always_comb begin
        tmo      = (state == MEM_WAIT) && (cnt == TW'(MEM_TIMEOUT - 1)) && !hz.i_MemReadyM;
        memstall = ((state == RUN) && hz.i_MemReqM && !hz.i_MemReadyM) ||
                   ((state == MEM_WAIT) && !hz.i_MemReadyM && !tmo);
        // r0 is hardwired to zero, so it never carries a real dependency
        lu = (hz.i_MemtoRegE == MEMTOREG_LOAD) && (hz.i_RtE != '0) &&
             ((hz.i_RtE == hz.i_RsD) || (hz.i_RtE == hz.i_RtD));
        bu = hz.i_BranchD && hz.i_RegWriteE && (hz.i_WriteRegE != '0) &&
             ((hz.i_WriteRegE == hz.i_RsD) || (hz.i_WriteRegE == hz.i_RtD));
    end

    always_comb begin
        we_f = 1'b0; we_d = 1'b0; we_e = 1'b0; we_m = 1'b0; we_w = 1'b0;
        clr_d = 1'b0; clr_e = 1'b0; clr_w = 1'b0;
        if (Reset) begin
            clr_d = 1'b1; clr_e = 1'b1; clr_w = 1'b1;
        end else if (memstall) begin
            // Freeze everything up to EX/MEM; WB drains with a bubble
            we_f = 1'b1; we_d = 1'b1; we_e = 1'b1; we_m = 1'b1;
            clr_w = 1'b1;
        end else if (lu || bu) begin
            // A redirect from ID is dropped; the stalled branch re-resolves next cycle
            we_f = 1'b1; we_d = 1'b1;
            clr_e = 1'b1;
        end else if (hz.i_PCSrcD) begin
            clr_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (Reset) begin
            state   <= RUN;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= tmo;
            case (state)
                RUN: begin
                    if (hz.i_MemReqM && !hz.i_MemReadyM) begin
                        state <= MEM_WAIT;
                        cnt   <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (hz.i_MemReadyM || tmo) state <= RUN;
                    else                       cnt   <= cnt + 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign hz.o_WE_nF  = we_f;
    assign hz.o_WE_nD  = we_d;
    assign hz.o_WE_nE  = we_e;
    assign hz.o_WE_nM  = we_m;
    assign hz.o_WE_nW  = we_w;
    assign hz.o_CLR_D  = clr_d;
    assign hz.o_CLR_E  = clr_e;
    assign hz.o_CLR_W  = clr_w;
    assign hz.o_MemErr = mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    mips_hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .i_Clk     (i_Clk),
        .Reset     (Reset),
        .stall_inc (we_f),
        .flush_inc (clr_d | clr_e),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    assign hz.o_StallCnt = stall_cnt;
    assign hz.o_FlushCnt = flush_cnt;
`else
    assign hz.o_StallCnt = '0;
    assign hz.o_FlushCnt = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed plus randomized bench for mips_hazard_ctrl against a cycle-level
// reference model built from the hazard rules (MEM_TIMEOUT=4, CNT_W=8).
module tb_mips_hazard_ctrl;
    import mips_hazard_pkg::*;

    localparam int T  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_hazard_ctrl_if #(.CNT_W(CW)) hz();

    mips_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .i_Clk (clk),
        .Reset (rst),
        .hz    (hz)
    );

    int checks   = 0;
    int failures = 0;

    // Model: an access in progress and how many cycles it has stalled so far
    bit m_acc     = 1'b0;
    int m_stalled = 0;
    bit m_err     = 1'b0;
    int m_sc      = 0;
    int m_fc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input int rsd, input int rtd, input bit br,
                        input bit pcs, input int rte, input int wre, input bit regw,
                        input logic [1:0] m2r, input bit req, input bit rdy);
        bit ms, tmo, lu, bu;
        logic [7:0] exp_ctl, obs_ctl;
        @(negedge clk);
        rst = r;
        hz.i_RsD = 5'(rsd);  hz.i_RtD = 5'(rtd);  hz.i_BranchD = br;
        hz.i_PCSrcD = pcs;   hz.i_RtE = 5'(rte);  hz.i_WriteRegE = 5'(wre);
        hz.i_RegWriteE = regw; hz.i_MemtoRegE = m2r;
        hz.i_MemReqM = req;  hz.i_MemReadyM = rdy;
        #1;
        ms  = (m_acc || req) && !rdy && (m_stalled < T);
        tmo = m_acc && !rdy && (m_stalled >= T);
        lu  = (m2r == MEMTOREG_LOAD) && rte != 0 && (rte == rsd || rte == rtd);
        bu  = br && regw && wre != 0 && (wre == rsd || wre == rtd);
        // order: WE F,D,E,M,W then CLR D,E,W
        if (r)            exp_ctl = 8'b00000_111;
        else if (ms)      exp_ctl = 8'b11110_001;
        else if (lu || bu) exp_ctl = 8'b11000_010;
        else if (pcs)     exp_ctl = 8'b00000_100;
        else              exp_ctl = 8'b00000_000;
        obs_ctl = {hz.o_WE_nF, hz.o_WE_nD, hz.o_WE_nE, hz.o_WE_nM, hz.o_WE_nW,
                   hz.o_CLR_D, hz.o_CLR_E, hz.o_CLR_W};
        chk("ctl", 32'(obs_ctl), 32'(exp_ctl));
        chk("memerr", 32'(hz.o_MemErr), 32'(m_err));
        chk("stallcnt", 32'(hz.o_StallCnt), 32'(m_sc));
        chk("flushcnt", 32'(hz.o_FlushCnt), 32'(m_fc));
        if (r) begin
            m_acc = 0; m_stalled = 0; m_err = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_err = tmo;
            if (ms) begin m_acc = 1; m_stalled++; end
            else    begin m_acc = 0; m_stalled = 0; end
`ifdef HAZARD_PERF_CNT_EN
            if (exp_ctl[7])            m_sc = (m_sc + 1) % (1 << CW);
            if (exp_ctl[2] | exp_ctl[1]) m_fc = (m_fc + 1) % (1 << CW);
`endif
        end
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        idle(1); idle(1); idle(0);

        // Load-use on r5, then cleared; RtE=0 load never stalls
        step(0, 5, 0, 0, 0, 5, 5, 1, 2'b01, 0, 0);
        chk("lu_weF", 32'(hz.o_WE_nF), 32'd1);
        step(0, 5, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("lu_done_weF", 32'(hz.o_WE_nF), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0);

        // Taken branch; then taken branch with load-use; then branch-operand hazard
        step(0, 1, 2, 1, 1, 0, 0, 0, 2'b00, 0, 0);
        chk("br_clrD", 32'(hz.o_CLR_D), 32'd1);
        step(0, 5, 0, 1, 1, 5, 5, 1, 2'b01, 0, 0);
        chk("br_lu_clrD", 32'(hz.o_CLR_D), 32'd0);
        step(0, 3, 4, 1, 0, 0, 4, 1, 2'b00, 0, 0);
        idle(0);

        // Memory wait: ready three cycles after the request
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1);
        chk("mw_ready_weF", 32'(hz.o_WE_nF), 32'd0);
        idle(0);

        // Watchdog: ready never arrives
        for (int i = 0; i < T + 1; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        idle(0);
        chk("tmo_err", 32'(hz.o_MemErr), 32'd1);
        idle(0); idle(0);

        // Reset while waiting abandons the access silently
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        idle(0);
        chk("rst_err", 32'(hz.o_MemErr), 32'd0);
        idle(0);

        // Two load-use stalls and one branch flush after a fresh reset
        idle(1); idle(0);
        step(0, 7, 0, 0, 0, 7, 7, 1, 2'b01, 0, 0);
        idle(0);
        step(0, 0, 9, 0, 0, 9, 9, 1, 2'b01, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
        idle(0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", 32'(hz.o_StallCnt), 32'd2);
        chk("perf_flush", 32'(hz.o_FlushCnt), 32'd3);
`endif

        // Randomized traffic on a narrow register range to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(63) == 0),
                 $urandom_range(3), $urandom_range(3), $urandom_range(1),
                 $urandom_range(1), $urandom_range(3), $urandom_range(3),
                 $urandom_range(1), 2'($urandom_range(3)),
                 ($urandom_range(9) < 4), ($urandom_range(9) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_hazard_ctrl.md
# mips_hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Every cycle it computes the active-low write enables and synchronous clear strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, which all use the same WE_n/CLR scheme as the ID/EX register. It resolves load-use and branch-operand hazards with single bubbles. It sequences multi-cycle data-memory accesses through a small FSM with a timeout watchdog.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before the access is abandoned (≥2)
- CNT_W, 32: width of the performance counters

Ports:
- i_Clk  in  1  core clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-high reset
- i_RsD, i_RtD  in  5 each  source register numbers of the instruction in ID
- i_BranchD  in  1  ID holds a branch comparing Rs/Rt in ID
- i_PCSrcD  in  1  branch/jump in ID is taken (redirect)
- i_RtE  in  5  destination register of a load in EX
- i_WriteRegE  in  5  destination register of the instruction in EX
- i_RegWriteE  in  1  EX instruction writes the register file
- i_MemtoRegE  in  2  EX result source; MEMTOREG_LOAD marks a load
- i_MemReqM  in  1  MEM-stage instruction accesses data memory
- i_MemReadyM  in  1  data memory completes the access this cycle
- o_WE_nF, o_WE_nD, o_WE_nE, o_WE_nM, o_WE_nW  out  1 each  active-low enables for PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- o_CLR_D, o_CLR_E, o_CLR_W  out  1 each  synchronous clears (insert bubble) for IF/ID, ID/EX, MEM/WB
- o_MemErr  out  1  one-cycle pulse on memory timeout
- o_StallCnt, o_FlushCnt  out  CNT_W each  performance counters (see Configuration)

## Operation
- Enable and clear outputs are combinational from inputs plus registered FSM state. o_MemErr and the counters are registered.
- Memory stall (memstall), the highest priority. Active when (state==RUN & i_MemReqM & ~i_MemReadyM) or (state==MEM_WAIT & ~i_MemReadyM & ~tmo). Effect: o_WE_nF/D/E/M=1 and o_CLR_W=1. The MEM/WB register stays enabled and loads a bubble.
- Load-use (lu): i_MemtoRegE==MEMTOREG_LOAD and i_RtE≠0 and (i_RtE==i_RsD or i_RtE==i_RtD).
- Branch-operand (bu): i_BranchD & i_RegWriteE & i_WriteRegE≠0 & (i_WriteRegE==i_RsD or i_WriteRegE==i_RtD).
- If ~memstall & (lu|bu): o_WE_nF=o_WE_nD=1 and o_CLR_E=1. A pending i_PCSrcD is ignored this cycle.
- If ~memstall & ~lu & ~bu & i_PCSrcD: o_CLR_D=1 and all enables low.
- Otherwise all enables are 0 and all clears are 0.
- Register 0 never creates a hazard.
- FSM states are RUN and MEM_WAIT.
  - RUN→MEM_WAIT on i_MemReqM & ~i_MemReadyM. The cycle counter is cleared to 0 on entry.
  - MEM_WAIT→RUN on i_MemReadyM. That cycle is not stalled and the pipeline advances.
  - MEM_WAIT→RUN on tmo, where tmo = (cnt==MEM_TIMEOUT-1) & ~i_MemReadyM. That cycle is not stalled, and o_MemErr pulses high the following cycle.
  - The counter increments each MEM_WAIT cycle. Its width is $clog2(MEM_TIMEOUT).
- While Reset=1: all o_WE_n*=0 and all o_CLR_*=1, so the pipeline loads bubbles. State becomes RUN, the counter becomes 0, and o_MemErr, o_StallCnt and o_FlushCnt become 0. Reset taken during MEM_WAIT abandons the access without an o_MemErr pulse.

## Timing
- Hazard detection has zero latency: the enables and clears are valid in the same cycle as the inputs.
- Load-use and branch-operand stalls each last exactly 1 cycle, because the hazard clears once the bubble reaches EX.
- Memory stall length is the number of cycles until i_MemReadyM, capped at MEM_TIMEOUT.
- i_MemReadyM in the same cycle as i_MemReqM in RUN causes no stall and no FSM transition.
- o_MemErr rises in the cycle after the timeout transition and lasts exactly 1 cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - o_StallCnt increments in every cycle with o_WE_nF=1.
  - o_FlushCnt increments in every cycle with o_CLR_D=1 or o_CLR_E=1.
  - Both counters wrap modulo 2^CNT_W.
- Not defined: the counter registers are absent and both ports are tied to 0.

## Structure
- Package mips_hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT)
  - MEMTOREG_LOAD = 2'b01
  - the register-number width constant (5)
- Sub-module mips_hazard_perf_cnt holds the two counters. It is instantiated only under HAZARD_PERF_CNT_EN.

## Test plan
- Load-use: EX holds a load with RtE=5 and ID has RsD=5 → one cycle with o_WE_nF=o_WE_nD=1 and o_CLR_E=1, then enables return to 0. RtE=0 produces no stall.
- Taken branch with no hazard: i_PCSrcD=1 → o_CLR_D=1 for 1 cycle and all enables 0. Adding load-use on the same cycle → stall instead, with o_CLR_D=0.
- Memory wait: i_MemReqM=1 with i_MemReadyM arriving 3 cycles later → F/D/E/M held for exactly 3 cycles with o_CLR_W=1. The ready cycle advances normally.
- Timeout with MEM_TIMEOUT=4 and i_MemReadyM never asserted → stall lasts 4 cycles, the watchdog ends it, o_MemErr pulses 1 cycle later, and the FSM returns to RUN.
- Reset mid-MEM_WAIT: Reset=1 → the next cycle shows state RUN, o_MemErr=0 and counters 0. While Reset=1, all clears are 1 and all enables are 0.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls plus 1 branch flush → o_StallCnt=2 and o_FlushCnt=3.
